// File: rtl/riscv_core_dcache_mem_pkg.sv
// Shared types and constants for the data-cache memory responder.
package riscv_core_dcache_mem_pkg;

    // Responder FSM states; IDLE is the only non-busy state.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_BEAT  = 3'd2,
        RD_DONE  = 3'd3,
        WR_WAIT  = 3'd4,
        WR_APPLY = 3'd5,
        WR_DONE  = 3'd6
    } mem_state_e;

    localparam int DEFAULT_READ_LATENCY  = 4;
    localparam int DEFAULT_WRITE_LATENCY = 2;

    // RD_BEAT issues four word addresses, then spends one more cycle
    // collecting the last registered RAM output.
    localparam int LINE_WORDS     = 4;
    localparam int RD_BEAT_CYCLES = LINE_WORDS + 1;

    // Phase counter width; comfortably covers any sensible latency.
    localparam int CNT_W = 16;

endpackage

// File: rtl/riscv_core_mem_backing_ram.sv
// Single-port backing store: synchronous 1-cycle read, byte-enable write.
// Contents have no reset, so they survive a responder reset.
module riscv_core_mem_backing_ram
    import riscv_core_dcache_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4096
) (
    input  logic                          i_clk,
    input  logic [$clog2(DEPTH)-1:0]      addr,
    input  logic                          we,
    input  logic [DATA_WIDTH/8-1:0]       be,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write and registered read of the addressed word.
    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/riscv_core_dcache_mem_responder.sv
// Behavioural memory responder behind the data cache: serves 4-word line
// reads and write-through word stores with fixed, parameterised latency.
//
// Handshake: a requester raises i_mem_read_req or i_mem_write_valid and
// holds it (with stable payload) until the matching one-cycle done pulse.
// The request is accepted on any clock edge where the responder is IDLE;
// write wins if both are high. Payload is latched at acceptance, so later
// input changes or a dropped request do not affect the transaction.
module riscv_core_dcache_mem_responder
    import riscv_core_dcache_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int CORE_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int MEM_DEPTH_WORDS = 4096,
    parameter int READ_LATENCY    = DEFAULT_READ_LATENCY,
    parameter int WRITE_LATENCY   = DEFAULT_WRITE_LATENCY
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_mem_read_req,
    input  logic [ADDR_WIDTH-1:0]        i_mem_read_address,
    output logic                         o_mem_read_done,
    output logic [AXI_DATA_WIDTH-1:0]    o_mem_read_data,
    input  logic                         i_mem_write_valid,
    input  logic [CORE_DATA_WIDTH-1:0]   i_mem_write_data,
    input  logic [ADDR_WIDTH-1:0]        i_mem_write_address,
    input  logic [CORE_DATA_WIDTH/8-1:0] i_mem_write_strobe,
    output logic                         o_mem_write_done,
    output logic                         o_busy,
    output logic [2:0]                   o_dbg_state
);

    localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
    localparam int BE_W  = CORE_DATA_WIDTH / 8;

    mem_state_e                 state_q;
    mem_state_e                 state_d;
    logic [CNT_W-1:0]           cnt_q;

    // Latched transaction payload.
    logic [IDX_W-3:0]           rd_line_q;
    logic [IDX_W-1:0]           wr_idx_q;
    logic [CORE_DATA_WIDTH-1:0] wr_data_q;
    logic [BE_W-1:0]            wr_strb_q;

    // Lower three words of the line being assembled.
    logic [CORE_DATA_WIDTH-1:0] lane_q [LINE_WORDS-1];

    logic [IDX_W-1:0]           ram_addr;
    logic                       ram_we;
    logic [CORE_DATA_WIDTH-1:0] ram_rdata;

    // Byte offset and address bits above the store depth are ignored,
    // which makes accesses wrap modulo the depth.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_mem_read_address[ADDR_WIDTH-1:IDX_W+3],
                                i_mem_read_address[4:0],
                                i_mem_write_address[ADDR_WIDTH-1:IDX_W+3],
                                i_mem_write_address[2:0]};

    // State register and per-phase cycle counter (restarts on every transition).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
        end
    end

    // Next-state decode, status outputs and RAM port steering.
    always_comb begin
        state_d          = state_q;
        o_mem_read_done  = 1'b0;
        o_mem_write_done = 1'b0;
        o_busy           = (state_q != IDLE);
        ram_addr         = wr_idx_q;
        ram_we           = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_mem_write_valid) begin
                    state_d = WR_WAIT;
                end else if (i_mem_read_req) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
                    state_d = RD_BEAT;
                end
            end
            RD_BEAT: begin
                ram_addr = {rd_line_q, cnt_q[1:0]};
                if (cnt_q == CNT_W'(RD_BEAT_CYCLES - 1)) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                o_mem_read_done = 1'b1;
                state_d         = IDLE;
            end
            WR_WAIT: begin
                if (cnt_q == CNT_W'(WRITE_LATENCY - 1)) begin
                    state_d = WR_APPLY;
                end
            end
            WR_APPLY: begin
                ram_we  = 1'b1;
                state_d = WR_DONE;
            end
            WR_DONE: begin
                o_mem_write_done = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_dbg_state = state_q;

    // Capture request payload while idle; it freezes once the FSM leaves IDLE.
    always_ff @(posedge i_clk) begin
        if (state_q == IDLE) begin
            if (i_mem_write_valid) begin
                wr_idx_q  <= i_mem_write_address[IDX_W+2:3];
                wr_data_q <= i_mem_write_data;
                wr_strb_q <= i_mem_write_strobe;
            end else if (i_mem_read_req) begin
                rd_line_q <= i_mem_read_address[IDX_W+2:5];
            end
        end
    end

    // Assemble the line one cycle behind each issued word address; the
    // output register updates only when the whole line is available.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mem_read_data <= '0;
        end else if (state_q == RD_BEAT) begin
            if (cnt_q >= CNT_W'(1) && cnt_q <= CNT_W'(LINE_WORDS - 1)) begin
                lane_q[cnt_q[1:0] - 2'd1] <= ram_rdata;
            end else if (cnt_q == CNT_W'(LINE_WORDS)) begin
                o_mem_read_data <= {ram_rdata, lane_q[2], lane_q[1], lane_q[0]};
            end
        end
    end

    riscv_core_mem_backing_ram #(
        .DATA_WIDTH (CORE_DATA_WIDTH),
        .DEPTH      (MEM_DEPTH_WORDS)
    ) u_ram (
        .i_clk (i_clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (wr_strb_q),
        .wdata (wr_data_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_riscv_core_dcache_mem_responder.sv
// Self-checking bench for the data-cache memory responder.
module tb_riscv_core_dcache_mem_responder;

    localparam int RL    = 4;
    localparam int WL    = 2;
    localparam int DEPTH = 4096;

    logic         clk;
    logic         rst;
    logic         rd_req;
    logic [63:0]  rd_addr;
    logic         rd_done;
    logic [255:0] rd_data;
    logic         wr_valid;
    logic [63:0]  wr_data;
    logic [63:0]  wr_addr;
    logic [7:0]   wr_strb;
    logic         wr_done;
    logic         busy;
    logic [2:0]   dbg_state;

    int total;
    int bad;

    // Reference word store keyed by word index, plus read scoreboard.
    logic [63:0]  model_mem [int];
    logic [255:0] exp_q [$];
    logic [255:0] msk_q [$];

    riscv_core_dcache_mem_responder #(
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_mem_read_req      (rd_req),
        .i_mem_read_address  (rd_addr),
        .o_mem_read_done     (rd_done),
        .o_mem_read_data     (rd_data),
        .i_mem_write_valid   (wr_valid),
        .i_mem_write_data    (wr_data),
        .i_mem_write_address (wr_addr),
        .i_mem_write_strobe  (wr_strb),
        .o_mem_write_done    (wr_done),
        .o_busy              (busy),
        .o_dbg_state         (dbg_state)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The two done pulses must never coincide.
    always @(negedge clk) begin
        if (!rst && (rd_done || wr_done)) begin
            total++;
            if (rd_done && wr_done) begin
                bad++;
                $display("FAIL done_exclusive rd_done=%b wr_done=%b required=not both", rd_done, wr_done);
            end
        end
    end

    function automatic int widx(input logic [63:0] a);
        return int'((a / 64'd8) % 64'(DEPTH));
    endfunction

    function automatic void model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        int i;
        logic [63:0] w;
        i = widx(a);
        w = model_mem.exists(i) ? model_mem[i] : 64'h0;
        for (int b = 0; b < 8; b++) begin
            if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        end
        if (s != 8'h00 || model_mem.exists(i)) model_mem[i] = w;
    endfunction

    function automatic void push_read(input logic [63:0] a);
        logic [255:0] e;
        logic [255:0] m;
        int i;
        e = '0;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            i = widx(a + 64'(k * 8));
            if (model_mem.exists(i)) begin
                e[k*64 +: 64] = model_mem[i];
                m[k*64 +: 64] = '1;
            end
        end
        exp_q.push_back(e);
        msk_q.push_back(m);
    endfunction

    // Idle wait unless chaining straight after a done pulse.
    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                            input bit b2b, input bit drop);
        int n;
        int acc;
        bit seen;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        acc = b2b ? 2 : 1;
        model_write(a, d, s);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_strb  = s;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (n == acc) begin
                wr_data = ~d;
                wr_addr = a ^ 64'h8;
                wr_strb = ~s;
                if (drop) wr_valid = 1'b0;
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL wr_busy got=%b exp=1", busy);
                end
            end
            if (wr_done) seen = 1'b1;
        end
        wr_valid = 1'b0;
        total++;
        if (!seen || n != acc + WL + 1) begin
            bad++;
            $display("FAIL wr_latency addr=%h got=%0d seen=%b exp=%0d", a, n, seen, acc + WL + 1);
        end
    endtask

    task automatic do_read(input logic [63:0] a, input bit b2b, input bit drop);
        int n;
        int acc;
        bit seen;
        logic [255:0] e;
        logic [255:0] m;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        acc = b2b ? 2 : 1;
        push_read(a);
        rd_req  = 1'b1;
        rd_addr = a;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (n == acc) begin
                rd_addr = a ^ 64'h20;
                if (drop) rd_req = 1'b0;
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL rd_busy got=%b exp=1", busy);
                end
            end
            if (rd_done) seen = 1'b1;
        end
        rd_req = 1'b0;
        total++;
        if (!seen || n != acc + RL + 5) begin
            bad++;
            $display("FAIL rd_latency addr=%h got=%0d seen=%b exp=%0d", a, n, seen, acc + RL + 5);
        end
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        total++;
        if ((rd_data & m) !== (e & m)) begin
            bad++;
            $display("FAIL rd_data addr=%h got=%h exp=%h", a, rd_data & m, e & m);
        end
    endtask

    task automatic watch_no_done(input int cycles, input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (rd_done || wr_done) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL %s got=done_pulse exp=no_done", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++;
        if (rd_done !== 1'b0) begin bad++; $display("FAIL reset_rd_done got=%b exp=0", rd_done); end
        total++;
        if (wr_done !== 1'b0) begin bad++; $display("FAIL reset_wr_done got=%b exp=0", wr_done); end
        total++;
        if (rd_data !== 256'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        total++;
        if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        do_write(64'h100, 64'h1122334455667788, 8'hFF, 1'b0, 1'b0);
        do_read(64'h100, 1'b0, 1'b0);
        total++;
        if (rd_data[63:0] !== 64'h1122334455667788) begin
            bad++;
            $display("FAIL write_read_word got=%h exp=%h", rd_data[63:0], 64'h1122334455667788);
        end
    endtask

    task automatic test_line_read();
        logic [255:0] line;
        line = {64'hDDDD0000DDDD0003, 64'hCCCC0000CCCC0002, 64'hBBBB0000BBBB0001, 64'hAAAA0000AAAA0000};
        do_write(64'h200, line[63:0],    8'hFF, 1'b0, 1'b0);
        do_write(64'h208, line[127:64],  8'hFF, 1'b1, 1'b0);
        do_write(64'h210, line[191:128], 8'hFF, 1'b1, 1'b0);
        do_write(64'h218, line[255:192], 8'hFF, 1'b1, 1'b0);
        do_read(64'h200, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (rd_data !== line) begin bad++; $display("FAIL line_hold_idle got=%h exp=%h", rd_data, line); end
        do_write(64'h300, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 1'b0);
        total++;
        if (rd_data !== line) begin bad++; $display("FAIL line_hold_write got=%h exp=%h", rd_data, line); end
    endtask

    task automatic test_partial();
        do_write(64'h100, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 1'b0);
        do_write(64'h104, 64'hAAAAAAAA00000000, 8'hF0, 1'b1, 1'b0);
        do_read(64'h100, 1'b1, 1'b0);
        total++;
        if (rd_data[63:0] !== 64'hAAAAAAAAFFFFFFFF) begin
            bad++;
            $display("FAIL partial_merge got=%h exp=%h", rd_data[63:0], 64'hAAAAAAAAFFFFFFFF);
        end
    endtask

    task automatic test_zero_strobe();
        do_write(64'h208, 64'h5A5A5A5A5A5A5A5A, 8'h00, 1'b0, 1'b0);
        do_read(64'h200, 1'b1, 1'b0);
        total++;
        if (rd_data[127:64] !== 64'hBBBB0000BBBB0001) begin
            bad++;
            $display("FAIL zero_strobe got=%h exp=%h", rd_data[127:64], 64'hBBBB0000BBBB0001);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        int wn;
        int rn;
        logic [255:0] e;
        logic [255:0] m;
        @(posedge clk);
        #1;
        model_write(64'h300, 64'hFEEDFACECAFEBEEF, 8'hFF);
        push_read(64'h300);
        wr_valid = 1'b1;
        wr_addr  = 64'h300;
        wr_data  = 64'hFEEDFACECAFEBEEF;
        wr_strb  = 8'hFF;
        rd_req   = 1'b1;
        rd_addr  = 64'h300;
        n  = 0;
        wn = 0;
        rn = 0;
        while (rn == 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (wr_done && wn == 0) begin
                wn = n;
                wr_valid = 1'b0;
            end
            if (rd_done) begin
                rn = n;
                rd_req = 1'b0;
            end
        end
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        total++;
        if (wn != WL + 2) begin bad++; $display("FAIL simul_wr_cycle got=%0d exp=%0d", wn, WL + 2); end
        total++;
        if (rn != WL + 2 + 2 + RL + 5) begin
            bad++;
            $display("FAIL simul_rd_cycle got=%0d exp=%0d", rn, WL + 2 + 2 + RL + 5);
        end
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        total++;
        if ((rd_data & m) !== (e & m)) begin bad++; $display("FAIL simul_rd_data got=%h exp=%h", rd_data & m, e & m); end
    endtask

    task automatic test_drop();
        do_write(64'h210, 64'h7777666655554444, 8'h3C, 1'b0, 1'b1);
        do_read(64'h200, 1'b0, 1'b1);
    endtask

    task automatic test_reset_rd_beat();
        @(posedge clk);
        #1;
        rd_req  = 1'b1;
        rd_addr = 64'h200;
        repeat (6) @(posedge clk);
        #1;
        rd_req = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_rd_busy got=%b exp=0", busy); end
        total++;
        if (dbg_state !== 3'd0) begin bad++; $display("FAIL rst_rd_state got=%0d exp=0", dbg_state); end
        watch_no_done(15, "rst_rd_no_done");
        do_read(64'h200, 1'b0, 1'b0);
    endtask

    task automatic test_reset_wr_wait();
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_addr  = 64'h208;
        wr_data  = 64'h0BADC0DE0BADC0DE;
        wr_strb  = 8'hFF;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_wr_busy got=%b exp=0", busy); end
        watch_no_done(10, "rst_wr_no_done");
        do_read(64'h200, 1'b0, 1'b0);
        total++;
        if (rd_data[127:64] !== 64'hBBBB0000BBBB0001) begin
            bad++;
            $display("FAIL rst_wr_unchanged got=%h exp=%h", rd_data[127:64], 64'hBBBB0000BBBB0001);
        end
    endtask

    task automatic test_alias();
        do_write(64'h8000, 64'hA11A5A11A5A11A5E, 8'hFF, 1'b0, 1'b0);
        do_read(64'h0, 1'b1, 1'b0);
        total++;
        if (rd_data[63:0] !== 64'hA11A5A11A5A11A5E) begin
            bad++;
            $display("FAIL alias_word0 got=%h exp=%h", rd_data[63:0], 64'hA11A5A11A5A11A5E);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        logic [63:0] d;
        for (int k = 0; k < 8; k++) begin
            d = {$urandom, $urandom};
            do_write(64'h400 + 64'(k * 8), d, 8'hFF, k != 0, 1'b0);
        end
        for (int k = 0; k < 14; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = 64'h400 + 64'($urandom_range(0, 7) * 8);
                d = {$urandom, $urandom};
                do_write(a, d, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
            end else begin
                a = 64'h400 + 64'($urandom_range(0, 1) * 32);
                do_read(a, 1'b1, 1'b0);
            end
        end
        do_read(64'h400, 1'b1, 1'b0);
        do_read(64'h420, 1'b1, 1'b0);
    endtask

    // Test sequence and final report.
    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        rd_req   = 1'b0;
        rd_addr  = '0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_addr  = '0;
        wr_strb  = '0;
        test_reset();
        test_write_read();
        test_line_read();
        test_partial();
        test_zero_strobe();
        test_simultaneous();
        test_drop();
        test_reset_rd_beat();
        test_reset_wr_wait();
        test_alias();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
